axi_lite_reg_sequencer: RTL

- Sequences one AXI4-Lite slave port onto a single-port, one-outstanding register bus used by SoC peripheral register files.
- Buffers AW, W and AR independently and pairs AW with W.
- Arbitrates round-robin between a ready write and a ready read.
- Drives one register access at a time and returns the B or R response with full AXI valid/ready handshaking.

---
 rtl/ariane_axi_soc.sv | 45 ++++
 rtl/axi_lite_reg_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ariane_axi_soc.sv
// AXI4-Lite request/response structs shared by SoC peripheral bridges.
// 64-bit address and data; register bridges use only the low 32 bits.
package ariane_axi_soc;

  typedef struct packed {
    logic [63:0] addr;
    logic [2:0]  prot;
  } ax_lite_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
  } w_lite_t;

  typedef struct packed {
    logic [1:0] resp;
  } b_lite_t;

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  resp;
  } r_lite_t;

  typedef struct packed {
    ax_lite_t aw;
    logic     aw_valid;
    w_lite_t  w;
    logic     w_valid;
    logic     b_ready;
    ax_lite_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_lite_t;

  typedef struct packed {
    logic     aw_ready;
    logic     w_ready;
    b_lite_t  b;
    logic     b_valid;
    logic     ar_ready;
    r_lite_t  r;
    logic     r_valid;
  } resp_lite_t;

endpackage

// File: rtl/axi_lite_reg_sequencer.sv
// AXI4-Lite slave to single-outstanding register bus sequencer.
// AW, W and AR are each held in a one-entry buffer; a complete AW/W pair
// and a buffered AR compete round-robin for the register bus, and the
// B/R response is held until the master accepts it.
// Optional macro AXI_LITE_REG_SEQ_TIMEOUT_EN: abort a register access
// with SLVERR after TimeoutCycles cycles without reg_ready_i.
module axi_lite_reg_sequencer #(
  parameter int unsigned TimeoutCycles = 256,
  parameter int unsigned CntWidth      = $clog2(TimeoutCycles + 1)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  ariane_axi_soc::req_lite_t  axi_req_i,
  output ariane_axi_soc::resp_lite_t axi_resp_o,
  output logic                       reg_req_o,
  output logic                       reg_we_o,
  output logic [31:0]                reg_addr_o,
  output logic [31:0]                reg_wdata_o,
  output logic [3:0]                 reg_wstrb_o,
  input  logic                       reg_ready_i,
  input  logic [31:0]                reg_rdata_i,
  input  logic                       reg_err_i
);

  typedef enum logic [2:0] {IDLE, WR_ACC, RD_ACC, WR_RSP, RD_RSP} state_t;
  typedef enum logic {GNT_READ, GNT_WRITE} grant_t;

  localparam logic [1:0]  RespOkay   = 2'b00;
  localparam logic [1:0]  RespSlvErr = 2'b10;
  localparam logic [31:0] AbortData  = 32'hDEAD_BEEF;

  state_t state_q, state_d;
  grant_t last_grant_q, last_grant_d;

  logic        aw_full_q, w_full_q, ar_full_q;
  logic [31:0] aw_addr_q, w_data_q, ar_addr_q;
  logic [3:0]  w_strb_q;
  logic [1:0]  b_resp_q, r_resp_q;
  logic [31:0] r_data_q;

  logic aw_ready, w_ready, ar_ready;
  logic aw_hs, w_hs, ar_hs;
  logic wr_rdy, rd_rdy;
  logic wr_done, rd_done;
  logic in_acc;
  logic timeout_hit;

  // Only the low 32 address/data bits and strb[3:0] reach the register bus.
  logic unused_in;
  assign unused_in = ^{axi_req_i.aw.addr[63:32], axi_req_i.aw.prot,
                       axi_req_i.w.data[63:32], axi_req_i.w.strb[7:4],
                       axi_req_i.ar.addr[63:32], axi_req_i.ar.prot};

  assign aw_ready = !aw_full_q && !rst_i;
  assign w_ready  = !w_full_q  && !rst_i;
  assign ar_ready = !ar_full_q && !rst_i;

  assign aw_hs = axi_req_i.aw_valid && aw_ready;
  assign w_hs  = axi_req_i.w_valid  && w_ready;
  assign ar_hs = axi_req_i.ar_valid && ar_ready;

  assign wr_rdy = aw_full_q && w_full_q;
  assign rd_rdy = ar_full_q;
  assign in_acc = (state_q == WR_ACC) || (state_q == RD_ACC);

`ifdef AXI_LITE_REG_SEQ_TIMEOUT_EN
  logic [CntWidth-1:0] tmo_cnt_q;

  // Wait counter: held at zero outside ACC, so each access starts from zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)             tmo_cnt_q <= '0;
    else if (!in_acc)      tmo_cnt_q <= '0;
    else if (!reg_ready_i) tmo_cnt_q <= tmo_cnt_q + 1'b1;
  end

  // A completing reg_ready_i on the limit cycle wins over the abort.
  assign timeout_hit = in_acc && !reg_ready_i &&
                       (tmo_cnt_q == CntWidth'(TimeoutCycles - 1));
`else
  logic [31:0] unused_cfg;
  assign unused_cfg  = TimeoutCycles + CntWidth;
  assign timeout_hit = 1'b0;
`endif

  // State register and round-robin history.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_READ;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Next state, grant and register-bus drive.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    wr_done      = 1'b0;
    rd_done      = 1'b0;
    reg_req_o    = 1'b0;
    reg_we_o     = 1'b0;
    reg_addr_o   = '0;
    reg_wdata_o  = '0;
    reg_wstrb_o  = '0;
    case (state_q)
      IDLE: begin
        if (wr_rdy && (!rd_rdy || last_grant_q == GNT_READ)) begin
          state_d      = WR_ACC;
          last_grant_d = GNT_WRITE;
        end else if (rd_rdy) begin
          state_d      = RD_ACC;
          last_grant_d = GNT_READ;
        end
      end
      WR_ACC: begin
        reg_req_o   = 1'b1;
        reg_we_o    = 1'b1;
        reg_addr_o  = aw_addr_q;
        reg_wdata_o = w_data_q;
        reg_wstrb_o = w_strb_q;
        if (reg_ready_i || timeout_hit) begin
          state_d = WR_RSP;
          wr_done = 1'b1;
        end
      end
      RD_ACC: begin
        reg_req_o  = 1'b1;
        reg_addr_o = ar_addr_q;
        if (reg_ready_i || timeout_hit) begin
          state_d = RD_RSP;
          rd_done = 1'b1;
        end
      end
      WR_RSP: if (axi_req_i.b_ready) state_d = IDLE;
      RD_RSP: if (axi_req_i.r_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request buffers: load on handshake, free when the access completes.
  // A buffer cannot handshake while full, so load and free never collide.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      ar_full_q <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      ar_addr_q <= '0;
    end else begin
      if (aw_hs) begin
        aw_full_q <= 1'b1;
        aw_addr_q <= axi_req_i.aw.addr[31:0];
      end else if (wr_done) begin
        aw_full_q <= 1'b0;
      end
      if (w_hs) begin
        w_full_q <= 1'b1;
        w_data_q <= axi_req_i.w.data[31:0];
        w_strb_q <= axi_req_i.w.strb[3:0];
      end else if (wr_done) begin
        w_full_q <= 1'b0;
      end
      if (ar_hs) begin
        ar_full_q <= 1'b1;
        ar_addr_q <= axi_req_i.ar.addr[31:0];
      end else if (rd_done) begin
        ar_full_q <= 1'b0;
      end
    end
  end

  // Response capture; without reg_ready_i the completion is an abort.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      b_resp_q <= RespOkay;
      r_resp_q <= RespOkay;
      r_data_q <= '0;
    end else begin
      if (wr_done)
        b_resp_q <= (!reg_ready_i || reg_err_i) ? RespSlvErr : RespOkay;
      if (rd_done) begin
        r_resp_q <= (!reg_ready_i || reg_err_i) ? RespSlvErr : RespOkay;
        r_data_q <= reg_ready_i ? reg_rdata_i : AbortData;
      end
    end
  end

  // AXI response assembly.
  always_comb begin
    axi_resp_o          = '0;
    axi_resp_o.aw_ready = aw_ready;
    axi_resp_o.w_ready  = w_ready;
    axi_resp_o.ar_ready = ar_ready;
    axi_resp_o.b_valid  = (state_q == WR_RSP);
    axi_resp_o.b.resp   = b_resp_q;
    axi_resp_o.r_valid  = (state_q == RD_RSP);
    axi_resp_o.r.resp   = r_resp_q;
    axi_resp_o.r.data   = {32'h0, r_data_q};
  end

endmodule
